sprite_compositor: RTL

SPRITE_COMPOSITOR -- requirements
Module: sprite_compositor

---
 rtl/compositor_pkg.sv | 29 ++
 rtl/sprite_hit_unit.sv | 35 +++
 rtl/sprite_compositor.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/compositor_pkg.sv
// Shared types and constants for the sprite compositor.
//   rgb_t        : 12-bit packed colour, 4 bits per channel (r in the MSBs)
//   COORD_W      : width of screen coordinates
//   SQ_*         : geometry of the ammo indicator squares
//   CURSOR_COLOR : colour of the diamond cursor
//   LIT_COLOR    : colour of a lit ammo square
package compositor_pkg;

  localparam int COORD_W = 10;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  // Square i spans x in [SQ_X0 + SQ_PITCH*i, SQ_X0 + SQ_PITCH*i + SQ_W)
  // and y in [SQ_Y0, SQ_Y1).
  localparam int SQ_X0    = 68;
  localparam int SQ_PITCH = 17;
  localparam int SQ_W     = 9;
  localparam int SQ_Y0    = 418;
  localparam int SQ_Y1    = 431;

  localparam rgb_t CURSOR_COLOR = '{r: 4'hF, g: 4'hF, b: 4'hF};
  localparam rgb_t LIT_COLOR    = '{r: 4'hF, g: 4'h8, b: 4'h0};
  localparam rgb_t BLACK        = '{r: 4'h0, g: 4'h0, b: 4'h0};

endpackage

// File: rtl/sprite_hit_unit.sv
// Per-sprite geometry: offset of the current pixel inside the sprite box,
// hit decision and sprite ROM address.
//   draw_x/draw_y : current pixel
//   spr_x/spr_y   : sprite top-left corner
//   spr_w/spr_h   : sprite size (0 disables the sprite)
//   spr_en        : sprite enable
//   hit           : pixel lies inside an enabled sprite
//   addr          : dy*spr_w + dx (14 bits) on a hit, else 0
import compositor_pkg::*;

module sprite_hit_unit (
  input  logic [COORD_W-1:0] draw_x,
  input  logic [COORD_W-1:0] draw_y,
  input  logic [COORD_W-1:0] spr_x,
  input  logic [COORD_W-1:0] spr_y,
  input  logic [6:0]         spr_w,
  input  logic [6:0]         spr_h,
  input  logic               spr_en,
  output logic               hit,
  output logic [13:0]        addr
);

  logic [COORD_W-1:0] dx;
  logic [COORD_W-1:0] dy;

  // Offsets wrap modulo 1024, so a pixel left of / above the sprite turns
  // into a large offset and fails the range test below.
  assign dx  = draw_x - spr_x;
  assign dy  = draw_y - spr_y;
  assign hit = spr_en && (dx < {3'b000, spr_w}) && (dy < {3'b000, spr_h});

  // Computed directly in 14 bits: the truncation is modular anyway.
  assign addr = hit ? (({4'd0, dy} * {7'd0, spr_w}) + {4'd0, dx}) : 14'd0;

endmodule

// File: rtl/sprite_compositor.sv
// Three-stage pixel compositor: sprites, diamond cursor, ammo squares and
// background are layered into a registered RGB output two cycles after a
// pixel coordinate is presented. Also keeps the ammo counter.
//   vga_clk, Reset                  : clock, synchronous active-high reset
//   DrawX, DrawY, blank             : current pixel and active-video flag
//   CursorX, CursorY, CursorSize    : diamond cursor centre and radius
//   SprX/SprY/SprW/SprH/SprEn       : per-sprite placement and enable
//   SprAddr / SprColor              : sprite ROM address out, colour back one cycle later
//   Fire, Reload                    : ammo controls (levels)
//   ShotsLeft                       : remaining ammo
//   Red, Green, Blue                : registered pixel colour
// Stage S0: geometry and ROM address (combinational, registered at its end).
// Stage S1: ROM data returns, layers are composed.
// Stage S2: output registers.
import compositor_pkg::*;

module sprite_compositor #(
  parameter int          NUM_SPR   = 2,
  parameter int          MAX_SHOTS = 3,
  parameter logic [11:0] KEY_COLOR = 12'h6AF,
  parameter logic [11:0] BG_COLOR  = 12'hAAA
) (
  input  logic                             vga_clk,
  input  logic                             Reset,
  input  logic [COORD_W-1:0]               DrawX,
  input  logic [COORD_W-1:0]               DrawY,
  input  logic                             blank,
  input  logic [COORD_W-1:0]               CursorX,
  input  logic [COORD_W-1:0]               CursorY,
  input  logic [COORD_W-1:0]               CursorSize,
  input  logic [NUM_SPR-1:0][COORD_W-1:0]  SprX,
  input  logic [NUM_SPR-1:0][COORD_W-1:0]  SprY,
  input  logic [NUM_SPR-1:0][6:0]          SprW,
  input  logic [NUM_SPR-1:0][6:0]          SprH,
  input  logic [NUM_SPR-1:0]               SprEn,
  output logic [NUM_SPR-1:0][13:0]         SprAddr,
  input  logic [NUM_SPR-1:0][11:0]         SprColor,
  input  logic                             Fire,
  input  logic                             Reload,
  output logic [3:0]                       ShotsLeft,
  output logic [3:0]                       Red,
  output logic [3:0]                       Green,
  output logic [3:0]                       Blue
);

  localparam logic [3:0] SHOTS_FULL = 4'(MAX_SHOTS);

  // ---------------- S0: geometry ----------------
  logic [NUM_SPR-1:0] hit;

  for (genvar g = 0; g < NUM_SPR; g++) begin : g_spr
    sprite_hit_unit u_hit (
      .draw_x (DrawX),
      .draw_y (DrawY),
      .spr_x  (SprX[g]),
      .spr_y  (SprY[g]),
      .spr_w  (SprW[g]),
      .spr_h  (SprH[g]),
      .spr_en (SprEn[g]),
      .hit    (hit[g]),
      .addr   (SprAddr[g])
    );
  end

  // Manhattan distance in 12-bit signed: two 10-bit magnitudes sum to at
  // most 2046, which still fits without overflow.
  logic signed [11:0] cdx, cdy, adx, ady, csum;
  logic               cursor_on;

  always_comb begin
    cdx       = $signed({2'b00, DrawX}) - $signed({2'b00, CursorX});
    cdy       = $signed({2'b00, DrawY}) - $signed({2'b00, CursorY});
    adx       = cdx[11] ? -cdx : cdx;
    ady       = cdy[11] ? -cdy : cdy;
    csum      = adx + ady;
    cursor_on = (csum <= $signed({2'b00, CursorSize}));
  end

  logic [3:0] shots;
  logic       square_lit;

  always_comb begin
    square_lit = 1'b0;
    for (int i = 0; i < MAX_SHOTS; i++) begin
      if (int'(DrawX) >= SQ_X0 + SQ_PITCH * i &&
          int'(DrawX) <  SQ_X0 + SQ_PITCH * i + SQ_W &&
          int'(DrawY) >= SQ_Y0 && int'(DrawY) < SQ_Y1 &&
          i < int'(shots))
        square_lit = 1'b1;
    end
  end

  // ---------------- S0 -> S1 registers ----------------
  logic               blank_q;
  logic               cursor_q;
  logic               lit_q;
  logic [NUM_SPR-1:0] hit_q;

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      blank_q  <= 1'b0;
      cursor_q <= 1'b0;
      lit_q    <= 1'b0;
      hit_q    <= '0;
    end else begin
      blank_q  <= blank;
      cursor_q <= cursor_on;
      lit_q    <= square_lit;
      hit_q    <= hit;
    end
  end

  // ---------------- S1: compose ----------------
  rgb_t pix;

  always_comb begin
    pix = rgb_t'(BG_COLOR);
    if (lit_q) pix = LIT_COLOR;
    // Walk from the highest index down so the lowest opaque sprite wins.
    for (int i = NUM_SPR - 1; i >= 0; i--) begin
      if (hit_q[i] && (SprColor[i] != KEY_COLOR)) pix = rgb_t'(SprColor[i]);
    end
    if (cursor_q) pix = CURSOR_COLOR;
    if (!blank_q) pix = BLACK;
  end

  // ---------------- S2: output registers ----------------
  rgb_t rgb_q;

  always_ff @(posedge vga_clk) begin
    if (Reset) rgb_q <= BLACK;
    else       rgb_q <= pix;
  end

  assign Red   = rgb_q.r;
  assign Green = rgb_q.g;
  assign Blue  = rgb_q.b;

  // ---------------- ammo counter ----------------
  logic fire_prev;

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      shots     <= SHOTS_FULL;
      fire_prev <= 1'b0;
    end else begin
      fire_prev <= Fire;
      if (Reload)                                    shots <= SHOTS_FULL;
      else if (Fire && !fire_prev && shots != 4'd0)  shots <= shots - 4'd1;
    end
  end

  assign ShotsLeft = shots;

endmodule
